// File: rtl/sprite_palette_encoder.sv
// Encodes a streamed 21x21 RGB sprite into 4-bit palette indices held in an internal index memory.
// Define SPRITE_NEAREST_EN to map unmatched colours to the nearest palette entry instead of 0.
module sprite_palette_encoder #(
  parameter int unsigned PIX_COUNT = 441,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned PAL_SIZE  = 7
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [23:0]       pix_color,
  input  logic [ADDR_W-1:0] read_address,
  output logic [3:0]        read_index,
  output logic              busy,
  output logic              done,
  output logic              miss_flag,
  output logic [ADDR_W-1:0] miss_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  localparam logic [23:0] Palette [7] = '{
    24'h800080, 24'hF83800, 24'hEA9A30, 24'hEF9D34, 24'h227DBB, 24'hFFA440, 24'hAC7C00
  };
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PIX_COUNT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] miss_count_q, miss_count_d;
  logic              miss_flag_q, miss_flag_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [3:0]        wr_idx_q;
  logic [3:0]        rd_q;
  logic [3:0]        mem [PIX_COUNT];

  logic       exact_hit;
  logic [3:0] exact_idx;
  logic [3:0] enc_idx;
  logic       accept;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    exact_hit = 1'b0;
    exact_idx = '0;
    for (int i = int'(PAL_SIZE) - 1; i >= 0; i--) begin
      if (pix_color == Palette[i]) begin
        exact_hit = 1'b1;
        exact_idx = 4'(i);
      end
    end
  end

`ifdef SPRITE_NEAREST_EN
  function automatic logic [9:0] rgb_dist(input logic [23:0] a, input logic [23:0] b);
    logic [7:0] dr, dg, db;
    dr = (a[23:16] > b[23:16]) ? a[23:16] - b[23:16] : b[23:16] - a[23:16];
    dg = (a[15:8] > b[15:8]) ? a[15:8] - b[15:8] : b[15:8] - a[15:8];
    db = (a[7:0] > b[7:0]) ? a[7:0] - b[7:0] : b[7:0] - a[7:0];
    return {2'b00, dr} + {2'b00, dg} + {2'b00, db};
  endfunction

  logic [3:0] near_idx;
  logic [9:0] near_dist;
  logic [9:0] cand_dist;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    cand_dist = '0;
    near_idx  = '0;
    near_dist = rgb_dist(pix_color, Palette[0]);
    for (int i = 1; i < int'(PAL_SIZE); i++) begin
      cand_dist = rgb_dist(pix_color, Palette[i]);
      if (cand_dist < near_dist) begin
        near_dist = cand_dist;
        near_idx  = 4'(i);
      end
    end
  end

  assign enc_idx = exact_hit ? exact_idx : near_idx;
`else
  assign enc_idx = exact_idx;
`endif

  assign accept = pix_valid & pix_ready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    miss_count_d = miss_count_q;
    miss_flag_d  = miss_flag_q;
    pix_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        done = (state_q == StDone);
        if (start) begin
          state_d      = StLoad;
          wr_ptr_d     = '0;
          miss_count_d = '0;
          miss_flag_d  = 1'b0;
        end
      end
      StLoad: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (pix_valid) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (!exact_hit) begin
            miss_flag_d  = 1'b1;
            miss_count_d = miss_count_q + ADDR_W'(1);
          end
          if (wr_ptr_q == LastAddr) state_d = StDrain;
        end
      end
      StDrain: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      miss_count_q <= '0;
      miss_flag_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_idx_q     <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      miss_count_q <= miss_count_d;
      miss_flag_q  <= miss_flag_d;
      wr_en_q      <= accept;
      if (accept) begin
        wr_addr_q <= wr_ptr_q;
        wr_idx_q  <= enc_idx;
      end
      // Same-cycle write to this address lands after the read, so old data is returned.
      rd_q <= (read_address <= LastAddr) ? mem[read_address] : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_idx_q;
  end

  assign read_index = rd_q;
  assign miss_flag  = miss_flag_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_sprite_palette_encoder.sv
// Randomised bench for sprite_palette_encoder against a frame-level reference model.
module tb_sprite_palette_encoder;

  localparam int NPix = 441;
  localparam logic [23:0] Pal [7] = '{
    24'h800080, 24'hF83800, 24'hEA9A30, 24'hEF9D34, 24'h227DBB, 24'hFFA440, 24'hAC7C00
  };

  logic        Clk, Reset_n, start, pix_valid, pix_ready, busy, done, miss_flag;
  logic [23:0] pix_color;
  logic [8:0]  read_address, miss_count;
  logic [3:0]  read_index;

  sprite_palette_encoder dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_color(pix_color), .read_address(read_address),
    .read_index(read_index), .busy(busy), .done(done), .miss_flag(miss_flag),
    .miss_count(miss_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_exact(input logic [23:0] c);
    for (int i = 0; i < 7; i++) if (c == Pal[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int model_index(input logic [23:0] c);
    logic [23:0] p;
    int best, bd, d;
    best = 0;
    bd   = 100000;
    for (int i = 0; i < 7; i++) if (c == Pal[i]) return i;
`ifdef SPRITE_NEAREST_EN
    for (int i = 0; i < 7; i++) begin
      p = Pal[i];
      d = absd(int'(c[23:16]), int'(p[23:16])) + absd(int'(c[15:8]), int'(p[15:8]))
        + absd(int'(c[7:0]), int'(p[7:0]));
      if (d < bd) begin
        bd   = d;
        best = i;
      end
    end
`endif
    return best;
  endfunction

  // Reference model: frame-level view of the load, indexed memory and read port.
  int   m_phase = 0;  // 0 idle, 1 loading, 2 finishing last write, 3 frame complete
  int   m_ptr = 0, m_miss = 0;
  int   m_mem [NPix];
  bit   m_known [NPix];
  bit   pend_v = 1'b0;
  int   pend_a, pend_d;
  int   exp_rd = 0;
  bit   rd_known = 1'b1;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      m_phase  = 0;
      m_miss   = 0;
      exp_rd   = 0;
      rd_known = 1'b1;
      pend_v   = 1'b0;
    end
    chk("pix_ready", 32'(pix_ready), 32'(m_phase == 1));
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("miss_count", 32'(miss_count), 32'(m_miss));
    chk("miss_flag", 32'(miss_flag), 32'(m_miss != 0));
    if (rd_known) chk("read_index", 32'(read_index), 32'(exp_rd));
    if (Reset_n) begin
      if (int'(read_address) < NPix) begin
        rd_known = m_known[read_address];
        exp_rd   = m_mem[read_address];
      end else begin
        rd_known = 1'b1;
        exp_rd   = 0;
      end
      if (pend_v) begin
        m_mem[pend_a]   = pend_d;
        m_known[pend_a] = 1'b1;
      end
      pend_v = 1'b0;
      case (m_phase)
        0, 3: if (start) begin
          m_phase = 1;
          m_ptr   = 0;
          m_miss  = 0;
        end
        1: if (pix_valid) begin
          pend_v = 1'b1;
          pend_a = m_ptr;
          pend_d = model_index(pix_color);
          if (!is_exact(pix_color)) m_miss++;
          m_ptr++;
          if (m_ptr == NPix) m_phase = 2;
        end
        default: m_phase = 3;
      endcase
    end
  end

  logic [23:0] frame_col [NPix];

  task automatic build(input int kind);
    for (int k = 0; k < NPix; k++) begin
      case (kind)
        0: frame_col[k] = Pal[k % 7];
        1: frame_col[k] = Pal[(k + 3) % 7];
        2: frame_col[k] = (k == 0 || k == NPix - 1) ? 24'h123456 : Pal[k % 7];
        default: frame_col[k] = ($urandom % 2 == 0) ? Pal[$urandom % 7] : 24'($urandom);
      endcase
    end
  endtask

  function automatic int frame_misses();
    int n = 0;
    for (int k = 0; k < NPix; k++) if (!is_exact(frame_col[k])) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // vmode: 0 continuous valid with colliding reads, 1 toggling valid, 2 random valid and start.
  task automatic load_frame(input int vmode, input int max_pix);
    int idx, guard;
    bit acc, tog;
    idx = 0;
    guard = 0;
    tog = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (idx < max_pix && guard < 4000) begin
      case (vmode)
        0: pix_valid = 1'b1;
        1: begin
          pix_valid = tog;
          tog = !tog;
        end
        default: pix_valid = ($urandom % 4) != 0;
      endcase
      start = (vmode == 2) && ($urandom % 40 == 0);
      pix_color = frame_col[idx];
      read_address = (vmode == 0) ? ((idx == 0) ? 9'd0 : 9'(idx - 1)) : 9'($urandom_range(0, 511));
      acc = pix_valid && pix_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    if (guard >= 4000) chk("load_timeout", 32'(idx), 32'(max_pix));
  endtask

  task automatic done_latency();
    int lat;
    lat = 1;
    while (!done && lat < 10) begin
      tick();
      lat++;
    end
    chk("done_latency", 32'(lat), 32'd2);
  endtask

  task automatic rd_chk(input string nm, input int a, input int exp);
    read_address = 9'(a);
    tick();
    chk(nm, 32'(read_index), 32'(exp));
  endtask

  int probe [6] = '{0, 1, 6, 7, 300, 440};

  initial begin
    Reset_n = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_color = '0;
    read_address = 9'd500;
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_read_index", 32'(read_index), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    Reset_n = 1'b1;

    // Idle: valid pixels must not be consumed.
    pix_valid = 1'b1;
    pix_color = Pal[1];
    repeat (10) tick();
    pix_valid = 1'b0;
    chk("idle_ready", 32'(pix_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Cycling palette frame, continuous valid.
    build(0);
    load_frame(0, NPix);
    done_latency();
    for (int i = 0; i < 6; i++) rd_chk("frameA_rd", probe[i], probe[i] % 7);
    chk("frameA_miss_count", 32'(miss_count), 32'd0);
    rd_chk("rd_oob_500", 500, 0);

    // Shifted frame overwrites with colliding reads, then same frame again with toggling valid.
    build(1);
    load_frame(0, NPix);
    done_latency();
    rd_chk("frameB_rd300", 300, (300 + 3) % 7);
    build(0);
    load_frame(1, NPix);
    done_latency();
    for (int i = 0; i < 6; i++) rd_chk("frameT_rd", probe[i], probe[i] % 7);

    // Unmatched pixels at both ends.
    build(2);
    load_frame(1, NPix);
    done_latency();
`ifdef SPRITE_NEAREST_EN
    rd_chk("miss_rd0", 0, 4);
    rd_chk("miss_rd440", 440, 4);
`else
    rd_chk("miss_rd0", 0, 0);
    rd_chk("miss_rd440", 440, 0);
`endif
    rd_chk("miss_rd1", 1, 1);
    chk("miss_flag_lit", 32'(miss_flag), 32'd1);
    chk("miss_count_lit", 32'(miss_count), 32'd2);

    // Reset during a load, then a clean frame.
    build(3);
    load_frame(2, 100);
    repeat (2) tick();
    Reset_n = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_miss", 32'(miss_count), 32'd0);
    build(0);
    load_frame(0, NPix);
    done_latency();
    chk("post_rst_miss", 32'(miss_count), 32'd0);
    chk("post_rst_done", 32'(done), 32'd1);

    // Random frames with random handshake, stray starts and random reads.
    for (int f = 0; f < 2; f++) begin
      build(3);
      load_frame(2, NPix);
      done_latency();
      chk("rand_miss_count", 32'(miss_count), 32'(frame_misses()));
    end
    for (int i = 0; i < 60; i++) begin
      read_address = 9'($urandom_range(0, 511));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_palette_encoder.md
Name: sprite_palette_encoder

Overview:
Writer side of the sprite palette ROMs: accepts a stream of 24-bit RGB pixels for one 21x21 Mario sprite, maps each colour to a 4-bit palette index, and stores the indices in an internal 441-entry index memory. A registered read port gives the same address-to-index view the sprite renderer expects. This lets the team load sprite frames at run time instead of only through hex files at elaboration.

Parameters:
PIX_COUNT, 441, number of pixels per sprite frame (21x21); addresses 0..PIX_COUNT-1
ADDR_W, 9, width of the read address and write pointer
PAL_SIZE, 7, number of valid palette entries (indices 0..PAL_SIZE-1)

Ports:
Clk  input  1  system clock; all state on the rising edge
Reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a frame load
pix_valid  input  1  pix_color holds a valid pixel
pix_ready  output  1  encoder accepts a pixel this cycle
pix_color  input  24  RGB pixel, 8 bits per channel, raster order
read_address  input  9  index-memory read address
read_index  output  4  palette index at read_address, 1-cycle latency
busy  output  1  high while a load is in progress
done  output  1  high once a full frame has been stored, until the next start
miss_flag  output  1  sticky: at least one pixel in this frame matched no palette entry
miss_count  output  9  number of unmatched pixels in this frame

Behaviour:
- Fixed palette in index order: 0 800080 (transparent), 1 F83800, 2 EA9A30, 3 EF9D34, 4 227DBB, 5 FFA440, 6 AC7C00.
- Reset (asynchronous, Reset_n=0): state IDLE; wr_ptr=0; pix_ready=0, busy=0, done=0, miss_flag=0, miss_count=0, read_index=0. Index-memory contents are not reset.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE: pix_ready=0. start goes to LOAD. On entry to LOAD, wr_ptr=0, miss_flag=0, miss_count=0, done=0.
- LOAD: pix_ready=1 and busy=1. A pixel is accepted only when pix_valid and pix_ready are both high.
- Colour matching: exact 24-bit compare against all entries. Lowest matching index wins. No match gives index 0, sets miss_flag and increments miss_count.
- Write pipeline: the accepted colour, its match result and wr_ptr are registered. The memory write happens the cycle after acceptance. wr_ptr increments on acceptance.
- When the accepted pixel has wr_ptr==PIX_COUNT-1, the FSM goes to DRAIN. In DRAIN, pix_ready=0 and the final write completes.
- DRAIN goes to DONE on the next cycle. In DONE, done=1, busy=0 and pix_ready=0.
- start in DONE or IDLE begins a new load. start during LOAD or DRAIN is ignored.
- pix_valid while pix_ready=0 is not consumed. The source must hold its data.
- Read port: read_index is registered from the memory at read_address, with latency 1 cycle, in all states.
  - read_address >= PIX_COUNT returns 0.
  - A read and a write to the same address in the same cycle return the old data.
- miss_count cannot exceed PIX_COUNT, so it never wraps.
- Reset mid-load: the FSM returns to IDLE with done=0. Partially written memory is left as-is and may be read.

Optional Feature:
SPRITE_NEAREST_EN.
- Defined: unmatched colours map to the nearest palette entry by the sum of absolute R, G and B differences (10-bit sum). Ties go to the lowest index. miss_flag and miss_count still count pixels that are not exact matches. The write latency is unchanged, so the distance logic must finish within the acceptance cycle.
- Undefined: exact match only; unmatched pixels give index 0.

Test Plan:
- Reset then idle: read_index=0, done=0, pix_ready=0; pix_valid=1 for 10 cycles -> no pixels consumed.
- start, then 441 pixels cycling through the 7 palette colours with continuous valid -> done rises 2 cycles after the last acceptance. read_address=k returns k mod 7. miss_count=0.
- Same frame with pix_valid toggling every other cycle -> identical memory contents. pix_ready stays 1 through LOAD.
- Pixels 0 and 440 set to 123456 -> read_index 0 at both addresses; miss_flag=1, miss_count=2. With SPRITE_NEAREST_EN, 123456 -> index 4 (227DBB is nearest).
- Reset_n pulled low after 100 pixels, then start and a full frame -> done=1 only after all 441 new pixels are accepted. miss_count reflects the new frame only.
- Read address 300 while pixel 300 is written in the same cycle -> old value returned; the new value is returned on the next read. read_address=500 returns 0.
